// File: rtl/pc_redirect_unit.sv
// IF-stage program counter with branch/jump redirect, stall-deferred redirect
// and halt. The PC counts instruction words, so offsets are added unshifted.
module pc_redirect_unit #(
  parameter int unsigned            PC_W     = 32,
  parameter logic [PC_W-1:0]        RESET_PC = {PC_W{1'b0}},
  parameter int unsigned            JT_W     = 26
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  input  logic [PC_W-1:0] pc_plus1_id,
  input  logic            jump,
  input  logic [JT_W-1:0] jump_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            if_flush,
  output logic            redirect_pending,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [PC_W-1:0] pend_addr_r, pend_addr_s;
  logic            pend_r, pend_s;
  logic            flush_r, flush_s;
  logic            halted_r, halted_s;
  logic            req_s;
  logic [PC_W-1:0] br_tgt_s, j_tgt_s, tgt_s;

  // Redirect target selection; jump has priority over a taken branch
  always_comb begin
    br_tgt_s = pc_plus1_id + branch_offset;
    j_tgt_s  = {pc_plus1_id[PC_W-1:JT_W], jump_target};
    req_s    = jump | branch_taken;
    if (jump) begin
      tgt_s = j_tgt_s;
    end else begin
      tgt_s = br_tgt_s;
    end
  end

  // Next-state and next-output logic for the fetch controller
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    pend_addr_s = pend_addr_r;
    pend_s      = pend_r;
    flush_s     = 1'b0;
    halted_s    = halted_r;
    case (state_r)
      ST_RUN: begin
        if (req_s && !stall) begin
          pc_s    = tgt_s;
          flush_s = 1'b1;
        end else if (req_s) begin
          pend_addr_s = tgt_s;
          pend_s      = 1'b1;
          state_s     = ST_HOLD;
        end else if (halt) begin
          state_s  = ST_HALTED;
          halted_s = 1'b1;
        end else if (stall) begin
          pc_s = pc_r;
        end else begin
          pc_s = pc_r + ONE;
        end
      end
      ST_HOLD: begin
        // The first latched redirect is the older one; later requests are dropped
        if (!stall) begin
          pc_s    = pend_addr_r;
          flush_s = 1'b1;
          pend_s  = 1'b0;
          state_s = ST_RUN;
        end else begin
          pc_s = pc_r;
        end
      end
      ST_HALTED: begin
        halted_s = 1'b1;
      end
      default: begin
        state_s  = ST_RUN;
        pend_s   = 1'b0;
        halted_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      pend_addr_r <= {PC_W{1'b0}};
      pend_r      <= 1'b0;
      flush_r     <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      pend_addr_r <= pend_addr_s;
      pend_r      <= pend_s;
      flush_r     <= flush_s;
      halted_r    <= halted_s;
    end
  end

  assign pc               = pc_r;
  assign pc_plus1         = pc_r + ONE;
  assign if_flush         = flush_r;
  assign redirect_pending = pend_r;
  assign halted           = halted_r;

endmodule
